// File: rtl/dilate_stream.sv
// Streaming 3x3 binary dilation over raster-scanned frames.
// A pixel history of two lines plus three pixels forms the window; frame counters mask the borders.
module dilate_stream #(
    parameter int unsigned ImgWidth  = 8,
    parameter int unsigned ImgHeight = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [8:0] element,
    input  logic       D,
    input  logic       D_valid,
    output logic       D_ready,
    output logic       Q,
    output logic       Q_valid,
    output logic       Q_last
);

    localparam int unsigned NumPx = ImgWidth * ImgHeight;
    localparam int unsigned CntW  = $clog2(NumPx);
    localparam int unsigned ColW  = $clog2(ImgWidth);
    localparam int unsigned RowW  = $clog2(ImgHeight);
    localparam int unsigned HistW = 2 * ImgWidth + 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]       state, state_next;
    logic [CntW-1:0]  in_cnt, in_cnt_next;
    logic [RowW-1:0]  row, row_next;
    logic [ColW-1:0]  col, col_next;
    logic [8:0]       elem_q, elem_next;
    logic [HistW-1:0] hist, hist_next;
    logic             q_next, q_valid_next, q_last_next, d_ready_next;

    logic             accept_c, flush_c, din_c, emit_c, out_last_c;
    logic [HistW:0]   win_c;
    logic [2:0]       row_ok_c, col_ok_c;
    logic [8:0]       hit_c;

    assign accept_c   = D_valid & D_ready;
    assign flush_c    = (state == ST_FLUSH);
    assign din_c      = flush_c ? 1'b0 : D;
    assign win_c      = {hist, din_c};
    assign emit_c     = flush_c | (accept_c & (in_cnt >= CntW'(ImgWidth + 1)));
    assign out_last_c = (row == RowW'(ImgHeight - 1)) && (col == ColW'(ImgWidth - 1));

    // Window row 0 reaches one line below the output pixel (reflected element), row 2 one line above.
    assign row_ok_c[0] = (row != RowW'(ImgHeight - 1));
    assign row_ok_c[1] = 1'b1;
    assign row_ok_c[2] = (row != '0);
    assign col_ok_c[0] = (col != ColW'(ImgWidth - 1));
    assign col_ok_c[1] = 1'b1;
    assign col_ok_c[2] = (col != '0);

    // Tap l*W+k of the history is A(row+1-l, col+1-k) relative to the output pixel.
    for (genvar l = 0; l < 3; l++) begin : g_row
        for (genvar k = 0; k < 3; k++) begin : g_col
            assign hit_c[l*3+k] = elem_q[l*3+k] & win_c[l*ImgWidth+k] & row_ok_c[l] & col_ok_c[k];
        end
    end

    always_comb begin
        state_next   = state;
        in_cnt_next  = in_cnt;
        row_next     = row;
        col_next     = col;
        elem_next    = elem_q;
        hist_next    = hist;
        q_next       = Q;
        q_valid_next = 1'b0;
        q_last_next  = 1'b0;
        d_ready_next = D_ready;

        case (state)
            ST_IDLE: begin
                if (accept_c) begin
                    elem_next   = element;
                    in_cnt_next = in_cnt + CntW'(1);
                    state_next  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept_c) begin
                    if (in_cnt == CntW'(NumPx - 1)) begin
                        in_cnt_next  = '0;
                        state_next   = ST_FLUSH;
                        d_ready_next = 1'b0;
                    end else begin
                        in_cnt_next = in_cnt + CntW'(1);
                    end
                end
            end
            ST_FLUSH: begin
                if (out_last_c) begin
                    state_next   = ST_IDLE;
                    d_ready_next = 1'b1;
                end
            end
            default: begin
                state_next   = ST_IDLE;
                in_cnt_next  = '0;
                d_ready_next = 1'b1;
            end
        endcase

        if (accept_c | flush_c) begin
            hist_next = win_c[HistW-1:0];
        end

        if (emit_c) begin
            q_next       = |hit_c;
            q_valid_next = 1'b1;
            q_last_next  = out_last_c;
            if (col == ColW'(ImgWidth - 1)) begin
                col_next = '0;
                row_next = out_last_c ? '0 : row + RowW'(1);
            end else begin
                col_next = col + ColW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            in_cnt  <= '0;
            row     <= '0;
            col     <= '0;
            elem_q  <= '0;
            hist    <= '0;
            Q       <= 1'b0;
            Q_valid <= 1'b0;
            Q_last  <= 1'b0;
            D_ready <= 1'b1;
        end else begin
            state   <= state_next;
            in_cnt  <= in_cnt_next;
            row     <= row_next;
            col     <= col_next;
            elem_q  <= elem_next;
            hist    <= hist_next;
            Q       <= q_next;
            Q_valid <= q_valid_next;
            Q_last  <= q_last_next;
            D_ready <= d_ready_next;
        end
    end

endmodule

// File: tb/tb_dilate_stream.sv
// Directed and randomized frames for dilate_stream, checked against a direct evaluation of the dilation formula.
module tb_dilate_stream;

    localparam int W = 8;
    localparam int H = 8;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] element = '0;
    logic       D = 1'b0;
    logic       D_valid = 1'b0;
    logic       D_ready, Q, Q_valid, Q_last;

    int n_tests = 0;
    int n_fail  = 0;
    logic [1:0] outq[$];

    dilate_stream #(.ImgWidth(W), .ImgHeight(H)) dut (
        .clk(clk), .rst_n(rst_n), .element(element), .D(D), .D_valid(D_valid),
        .D_ready(D_ready), .Q(Q), .Q_valid(Q_valid), .Q_last(Q_last)
    );

    always #5 clk = ~clk;

    // Every output pulse is recorded as {Q, Q_last}.
    always @(negedge clk) begin
        if (Q_valid) outq.push_back({Q, Q_last});
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model_px(input logic [N-1:0] img, input logic [8:0] e, input int r, input int c);
        for (int l = 0; l < 3; l++) begin
            for (int k = 0; k < 3; k++) begin
                int rr = r - (l - 1);
                int cc = c - (k - 1);
                if (e[l*3+k] && rr >= 0 && rr < H && cc >= 0 && cc < W && img[rr*W+cc]) return 1;
            end
        end
        return 0;
    endfunction

    task automatic drive_px(input logic d, input int gap_pct);
        int g = 0;
        while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct && g < 8) begin
            D_valid = 1'b0;
            D = 1'($urandom);
            @(negedge clk);
            g++;
        end
        D_valid = 1'b1;
        D = d;
        @(negedge clk);
        D_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [N-1:0] img, input logic [8:0] e0, input logic [8:0] e_mid,
                              input int gap_pct, input int n_px, input string tag);
        int low = 0;
        element = e0;
        for (int n = 0; n < n_px; n++) begin
            if (n == 1) element = e_mid;
            drive_px(img[n], gap_pct);
        end
        if (n_px == N) begin
            // Offer junk while flushing; it must not be consumed.
            D_valid = 1'b1;
            D = 1'b1;
            for (int t = 0; t < 50 && !D_ready; t++) begin
                low++;
                @(negedge clk);
            end
            D_valid = 1'b0;
            D = 1'b0;
            chk({tag, " ready_low_cycles"}, low, W + 1);
        end
    endtask

    task automatic check_frame(input logic [N-1:0] img, input logic [8:0] e, input int base, input string tag);
        for (int i = 0; i < N; i++) begin
            int exp = model_px(img, e, i / W, i % W) * 2 + ((i == N - 1) ? 1 : 0);
            int obs = (base + i < outq.size()) ? int'(outq[base+i]) : -1;
            chk($sformatf("%s px%0d {Q,last}", tag, i), obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " Q"}, int'(Q), 0);
        chk({tag, " Q_valid"}, int'(Q_valid), 0);
        chk({tag, " Q_last"}, int'(Q_last), 0);
        chk({tag, " D_ready"}, int'(D_ready), 1);
    endtask

    initial begin
        logic [N-1:0] img, img2;
        logic [8:0]   e0;

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Full element, single foreground pixel at (3,4).
        img = N'(1) << (3 * W + 4);
        outq.delete();
        send_frame(img, 9'h1FF, 9'h1FF, 0, N, "box");
        @(negedge clk);
        chk("box count", outq.size(), N);
        check_frame(img, 9'h1FF, 0, "box");

        // Single tap at window top-centre exposes the reflection.
        outq.delete();
        send_frame(img, 9'h002, 9'h002, 0, N, "reflect");
        @(negedge clk);
        chk("reflect count", outq.size(), N);
        check_frame(img, 9'h002, 0, "reflect");

        // Left-edge pixel, then a back-to-back zero frame.
        img = N'(1) << (1 * W + 0);
        outq.delete();
        send_frame(img, 9'h1FF, 9'h1FF, 0, N, "edge");
        send_frame('0, 9'h1FF, 9'h1FF, 0, N, "zero");
        @(negedge clk);
        chk("edge+zero count", outq.size(), 2 * N);
        check_frame(img, 9'h1FF, 0, "edge");
        check_frame('0, 9'h1FF, N, "zero");

        // Random image with gaps in D_valid.
        img = {$urandom, $urandom};
        outq.delete();
        send_frame(img, 9'h1FF, 9'h1FF, 50, N, "rand");
        @(negedge clk);
        chk("rand count", outq.size(), N);
        check_frame(img, 9'h1FF, 0, "rand");

        // Element changes after the first pixel; the latched value must be used.
        img = {$urandom, $urandom};
        e0 = 9'($urandom);
        outq.delete();
        send_frame(img, e0, ~e0, 50, N, "latch");
        @(negedge clk);
        chk("latch count", outq.size(), N);
        check_frame(img, e0, 0, "latch");

        // Abort a frame after 20 accepts with an asynchronous reset.
        img2 = {$urandom, $urandom};
        send_frame(img2, 9'h1FF, 9'h1FF, 0, 20, "abort");
        chk("abort pre-reset Q_valid", int'(Q_valid), 1);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("async reset");
        outq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame('0, 9'h000, 9'h000, 0, N, "post-reset");
        repeat (2) @(negedge clk);
        chk("post-reset count", outq.size(), N);
        check_frame('0, 9'h000, 0, "post-reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
